alctrl_commit_reader: RTL and testbench
=======================================

Name: alctrl_commit_reader

Overview:
- Commit-side reader of the active-list control RAM. Issue lanes write completion/control words into that RAM; this block reads them in program order.
- Keeps head/tail pointers and occupancy of the active list. Drives up to COMMIT_W read addresses starting at head each cycle.
- Decides how many oldest entries retire, then advances head. Detects head exceptions and sequences a pipeline flush.

Parameters:
DEPTH, 16, active-list entries; must equal 2**INDEX
INDEX, 4, pointer width
WIDTH, 8, control word width (minimum 3)
COMMIT_W, 4, commit lanes (1..4)
DISPATCH_W, 4, maximum entries dispatched per cycle

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
dispatchCnt_i  in  3  entries allocated this cycle (0..DISPATCH_W)
commitLaneActive_i  in  COMMIT_W  active commit lanes; must be contiguous from lane 0
stallCommit_i  in  1  downstream back-pressure; blocks all retirement
flushAck_i  in  1  recovery complete
rdAddr_o  out  COMMIT_W*INDEX  RAM read address per lane
rdData_i  in  COMMIT_W*WIDTH  RAM read data; asynchronous, valid in the same cycle
commitVld_o  out  COMMIT_W  registered per-lane retire strobe
commitPtr_o  out  INDEX  registered head value of the retiring group
commitCnt_o  out  3  registered count of retired entries
recoverFlag_o  out  1  high throughout FLUSH
head_o  out  INDEX  current head
tail_o  out  INDEX  current tail
alCount_o  out  INDEX+1  occupancy
alFull_o  out  1  high when alCount_o > DEPTH-DISPATCH_W

Behaviour:
- Reset: head, tail, count = 0. commitVld_o = 0. commitCnt_o = 0. commitPtr_o = 0. recoverFlag_o = 0. State = RUN. alFull_o = 0.
- Read addresses: rdAddr_o[k] = (head+k) mod DEPTH, combinational from head. Pointers wrap naturally at INDEX bits.
- Control word bits: DONE = bit0, EXCPT = bit1, MISPRED = bit2. Higher bits are ignored.
- Lane k is eligible when all of these hold:
  - state is RUN and stallCommit_i = 0;
  - k < count and commitLaneActive_i[k] = 1;
  - DONE = 1 and EXCPT = 0;
  - every lane j < k is eligible;
  - no lane j < k has MISPRED = 1. A mispredicted branch retires but terminates its group.
- n = number of eligible lanes. The retire mask is the lowest n bits.
- At the clock edge:
  - commitVld_o <= mask; commitCnt_o <= n; commitPtr_o <= old head.
  - head <= head+n; tail <= tail+dispatchCnt_i; count <= count + dispatchCnt_i − n.
  - Retire outputs therefore lag the RAM read by one cycle. The next cycle reads the new head.
- Same-cycle dispatch and commit: both apply; the net count arithmetic is done in INDEX+1 bits.
- Empty (count = 0): no lane is eligible, commitVld_o = 0.
- Full: count never exceeds DEPTH. Dispatch that would overflow is a protocol violation, covered by an assertion, not handled.
- FSM transitions:
  - RUN→FLUSH when all hold: count > 0, lane 0 has DONE = 1 and EXCPT = 1, stallCommit_i = 0, commitLaneActive_i[0] = 1. The exception entry is not retired.
  - recoverFlag_o becomes 1 on the edge entering FLUSH.
  - In FLUSH, dispatchCnt_i is ignored and commitVld_o = 0.
  - FLUSH→RUN when flushAck_i = 1. On that same edge: head, tail, count = 0 and recoverFlag_o = 0.
- flushAck_i while in RUN is ignored.
- Reset at any time, including mid-FLUSH, overrides all other activity and restores reset values the next cycle.
- Lanes with commitLaneActive_i = 0 never retire. When lane 0 is inactive, nothing retires.

Decomposition:
- Shared package: ALCTRL_DONE_BIT, ALCTRL_EXCPT_BIT and ALCTRL_MISPRED_BIT; the commit FSM state enum {RUN, FLUSH}.
- One sub-module, alctrl_commit_select: combinational priority logic from per-lane ctrl/valid to retire mask and n. It is reusable by the load/store queue commit path.

Test Plan:
- Dispatch 4, all four ctrl words = 0x01 → the cycle after the read: commitVld_o = 4'b1111, commitCnt_o = 4, commitPtr_o = 0, head = 4, count = 0.
- Head at 14, 4 entries, all done → rdAddr_o = {14,15,0,1}; head wraps to 2; commitPtr_o = 14.
- Ctrl words {0x01, 0x00, 0x01, 0x01} → commitVld_o = 4'b0001, head +1. Next cycle lane 0 is not done → commitVld_o = 0.
- Ctrl words {0x01, 0x05, 0x01, 0x01}:
  - commitVld_o = 4'b0011 (the mispredict at lane 1 ends the group).
  - Then lane 0 = 0x03 → recoverFlag_o = 1, and it stays 1 until flushAck_i.
  - At flushAck_i: recoverFlag_o = 0, head = tail = count = 0.
- commitLaneActive_i = 4'b0011 with 4 done entries → commitVld_o = 4'b0011. stallCommit_i = 1 → commitVld_o = 0 with head held.
- Fill to count = 13 with DISPATCH_W = 4 → alFull_o = 1. Dispatch 2 with commit 3 in the same cycle → count = 12, alFull_o = 0. Assert reset mid-FLUSH → all reset values.

Source files
------------

// File: rtl/alctrl_commit_reader_pkg.sv
// Shared types for the active-list commit reader.
// Control-word bit positions and the commit FSM state.
package alctrl_commit_reader_pkg;

  localparam int ALCTRL_DONE_BIT    = 0;
  localparam int ALCTRL_EXCPT_BIT   = 1;
  localparam int ALCTRL_MISPRED_BIT = 2;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } alctrl_state_e;

endpackage

// File: rtl/alctrl_commit_select.sv
// In-order retire selection over the oldest lanes.
// Produces a contiguous retire mask and its population count.
module alctrl_commit_select
  import alctrl_commit_reader_pkg::*;
#(
  parameter int COMMIT_W = 4,
  parameter int WIDTH    = 8
) (
  input  logic [COMMIT_W*WIDTH-1:0] ctrl,
  input  logic [COMMIT_W-1:0]       valid,
  output logic [COMMIT_W-1:0]       mask,
  output logic [2:0]                cnt
);

  logic             open;
  logic [WIDTH-1:0] word;
  logic             unused_ctrl;

  // Upper control bits are carried but carry no meaning here.
  assign unused_ctrl = ^ctrl;

  // Walk lanes oldest-first; a gap or a mispredict closes the group.
  always_comb begin
    mask = '0;
    cnt  = '0;
    open = 1'b1;
    word = '0;
    for (int k = 0; k < COMMIT_W; k++) begin
      word = ctrl[k*WIDTH +: WIDTH];
      if (open && valid[k] &&
          word[ALCTRL_DONE_BIT] &&
          !word[ALCTRL_EXCPT_BIT]) begin
        mask[k] = 1'b1;
        cnt     = cnt + 3'd1;
        open    = !word[ALCTRL_MISPRED_BIT];
      end else begin
        open = 1'b0;
      end
    end
  end

endmodule

// File: rtl/alctrl_commit_reader.sv
// Commit-side reader of the active-list control RAM.
// Tracks head/tail/occupancy, retires in order, sequences flush.
module alctrl_commit_reader
  import alctrl_commit_reader_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter int INDEX      = 4,
  parameter int WIDTH      = 8,
  parameter int COMMIT_W   = 4,
  parameter int DISPATCH_W = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [2:0]                dispatchCnt_i,
  input  logic [COMMIT_W-1:0]       commitLaneActive_i,
  input  logic                      stallCommit_i,
  input  logic                      flushAck_i,
  output logic [COMMIT_W*INDEX-1:0] rdAddr_o,
  input  logic [COMMIT_W*WIDTH-1:0] rdData_i,
  output logic [COMMIT_W-1:0]       commitVld_o,
  output logic [INDEX-1:0]          commitPtr_o,
  output logic [2:0]                commitCnt_o,
  output logic                      recoverFlag_o,
  output logic [INDEX-1:0]          head_o,
  output logic [INDEX-1:0]          tail_o,
  output logic [INDEX:0]            alCount_o,
  output logic                      alFull_o
);

  alctrl_state_e         state_q;
  alctrl_state_e         state_d;
  logic [INDEX-1:0]      head_q;
  logic [INDEX-1:0]      tail_q;
  logic [INDEX:0]        cnt_q;
  logic [INDEX:0]        cnt_d;
  logic [COMMIT_W-1:0]   lane_vld;
  logic [COMMIT_W-1:0]   ret_mask;
  logic [2:0]            ret_n;
  logic [2:0]            disp;
  logic                  run_en;
  logic                  head_excpt;
  logic                  flush_done;
  logic [INDEX+1:0]      cnt_chk;

  assign run_en = (state_q == RUN) && !stallCommit_i;
  assign disp   = (state_q == RUN) ? dispatchCnt_i : 3'd0;

  assign head_excpt = run_en && commitLaneActive_i[0] &&
                      (cnt_q != '0) &&
                      rdData_i[ALCTRL_DONE_BIT] &&
                      rdData_i[ALCTRL_EXCPT_BIT];

  assign flush_done = (state_q == FLUSH) && flushAck_i;

  assign cnt_d = cnt_q + (INDEX+1)'(disp)
               - (INDEX+1)'(ret_n);

  // One read address per lane, consecutive from head.
  always_comb begin
    rdAddr_o = '0;
    for (int k = 0; k < COMMIT_W; k++)
      rdAddr_o[k*INDEX +: INDEX] = head_q + INDEX'(k);
  end

  // Lane qualifies when occupied, active and commit enabled.
  always_comb begin
    lane_vld = '0;
    for (int k = 0; k < COMMIT_W; k++)
      lane_vld[k] = run_en && commitLaneActive_i[k] &&
                    (cnt_q > (INDEX+1)'(k));
  end

  alctrl_commit_select #(
    .COMMIT_W (COMMIT_W),
    .WIDTH    (WIDTH)
  ) u_select (
    .ctrl  (rdData_i),
    .valid (lane_vld),
    .mask  (ret_mask),
    .cnt   (ret_n)
  );

  // Next state: enter flush on head exception, leave on ack.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:   if (head_excpt) state_d = FLUSH;
      FLUSH: if (flushAck_i) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= RUN;
    else       state_q <= state_d;
  end

  // Pointers, occupancy and registered retire outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_q        <= '0;
      tail_q        <= '0;
      cnt_q         <= '0;
      commitVld_o   <= '0;
      commitCnt_o   <= '0;
      commitPtr_o   <= '0;
      recoverFlag_o <= 1'b0;
    end else begin
      commitVld_o   <= ret_mask;
      commitCnt_o   <= ret_n;
      commitPtr_o   <= head_q;
      recoverFlag_o <= (state_d == FLUSH);
      if (flush_done) begin
        head_q <= '0;
        tail_q <= '0;
        cnt_q  <= '0;
      end else begin
        head_q <= head_q + INDEX'(ret_n);
        tail_q <= tail_q + INDEX'(disp);
        cnt_q  <= cnt_d;
      end
    end
  end

  assign head_o    = head_q;
  assign tail_o    = tail_q;
  assign alCount_o = cnt_q;
  assign alFull_o  = cnt_q > (INDEX+1)'(DEPTH - DISPATCH_W);

  assign cnt_chk = (INDEX+2)'(cnt_q) + (INDEX+2)'(disp)
                 - (INDEX+2)'(ret_n);

  // Dispatch must never push occupancy past DEPTH.
  a_no_overflow: assert property (
    @(posedge clk) disable iff (reset)
    cnt_chk <= (INDEX+2)'(DEPTH));

  a_disp_range: assert property (
    @(posedge clk) disable iff (reset)
    dispatchCnt_i <= 3'(DISPATCH_W));

endmodule

// File: tb/tb_alctrl_commit_reader.sv
// Directed bench for the active-list commit reader.
// Control RAM is modelled here and read through rdAddr_o.
module tb_alctrl_commit_reader;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  dispatchCnt_i;
  logic [3:0]  commitLaneActive_i;
  logic        stallCommit_i;
  logic        flushAck_i;
  logic [15:0] rdAddr_o;
  logic [31:0] rdData_i;
  logic [3:0]  commitVld_o;
  logic [3:0]  commitPtr_o;
  logic [2:0]  commitCnt_o;
  logic        recoverFlag_o;
  logic [3:0]  head_o;
  logic [3:0]  tail_o;
  logic [4:0]  alCount_o;
  logic        alFull_o;

  logic [7:0]  ram [16];
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  alctrl_commit_reader dut (
    .clk                (clk),
    .reset              (reset),
    .dispatchCnt_i      (dispatchCnt_i),
    .commitLaneActive_i (commitLaneActive_i),
    .stallCommit_i      (stallCommit_i),
    .flushAck_i         (flushAck_i),
    .rdAddr_o           (rdAddr_o),
    .rdData_i           (rdData_i),
    .commitVld_o        (commitVld_o),
    .commitPtr_o        (commitPtr_o),
    .commitCnt_o        (commitCnt_o),
    .recoverFlag_o      (recoverFlag_o),
    .head_o             (head_o),
    .tail_o             (tail_o),
    .alCount_o          (alCount_o),
    .alFull_o           (alFull_o)
  );

  always_comb begin
    rdData_i = '0;
    for (int k = 0; k < 4; k++)
      rdData_i[k*8 +: 8] = ram[rdAddr_o[k*4 +: 4]];
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_ram();
    for (int i = 0; i < 16; i++) ram[i] = 8'h00;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    checks++; if (head_o !== 4'd0 || tail_o !== 4'd0 || alCount_o !== 5'd0) begin
      errors++; $display("FAIL reset_ptrs got h=%0d t=%0d c=%0d exp 0 0 0", head_o, tail_o, alCount_o); end
    checks++; if (commitVld_o !== 4'b0 || commitCnt_o !== 3'd0 || commitPtr_o !== 4'd0) begin
      errors++; $display("FAIL reset_commit got v=%b n=%0d p=%0d exp 0 0 0", commitVld_o, commitCnt_o, commitPtr_o); end
    checks++; if (recoverFlag_o !== 1'b0 || alFull_o !== 1'b0) begin
      errors++; $display("FAIL reset_flags got rec=%b full=%b exp 0 0", recoverFlag_o, alFull_o); end
    checks++; if (rdAddr_o !== 16'h3210) begin
      errors++; $display("FAIL reset_addr got=%h exp=3210", rdAddr_o); end
    reset = 1'b0;
  endtask

  task automatic test_full_group();
    for (int i = 0; i < 4; i++) ram[i] = 8'h01;
    dispatchCnt_i = 3'd4;
    step();
    checks++; if (alCount_o !== 5'd4 || tail_o !== 4'd4 || commitVld_o !== 4'b0) begin
      errors++; $display("FAIL disp4 got c=%0d t=%0d v=%b exp 4 4 0000", alCount_o, tail_o, commitVld_o); end
    dispatchCnt_i = 3'd0;
    step();
    checks++; if (commitVld_o !== 4'b1111 || commitCnt_o !== 3'd4 || commitPtr_o !== 4'd0) begin
      errors++; $display("FAIL grp4 got v=%b n=%0d p=%0d exp 1111 4 0", commitVld_o, commitCnt_o, commitPtr_o); end
    checks++; if (head_o !== 4'd4 || alCount_o !== 5'd0) begin
      errors++; $display("FAIL grp4_ptr got h=%0d c=%0d exp 4 0", head_o, alCount_o); end
    step();
    checks++; if (commitVld_o !== 4'b0) begin
      errors++; $display("FAIL empty_vld got=%b exp=0000", commitVld_o); end
  endtask

  task automatic test_wrap();
    for (int i = 4; i < 14; i++) ram[i] = 8'h01;
    dispatchCnt_i = 3'd4;
    step();
    step();
    dispatchCnt_i = 3'd2;
    step();
    checks++; if (head_o !== 4'd12 || tail_o !== 4'd14 || alCount_o !== 5'd2) begin
      errors++; $display("FAIL pre_wrap got h=%0d t=%0d c=%0d exp 12 14 2", head_o, tail_o, alCount_o); end
    dispatchCnt_i = 3'd0;
    step();
    checks++; if (commitVld_o !== 4'b0011 || head_o !== 4'd14 || alCount_o !== 5'd0) begin
      errors++; $display("FAIL cnt_limit got v=%b h=%0d c=%0d exp 0011 14 0", commitVld_o, head_o, alCount_o); end
    ram[14] = 8'h01;
    ram[15] = 8'h01;
    dispatchCnt_i = 3'd4;
    step();
    dispatchCnt_i = 3'd0;
    checks++; if (rdAddr_o !== 16'h10FE || tail_o !== 4'd2) begin
      errors++; $display("FAIL wrap_addr got a=%h t=%0d exp 10fe 2", rdAddr_o, tail_o); end
    step();
    checks++; if (commitVld_o !== 4'b1111 || commitPtr_o !== 4'd14 || head_o !== 4'd2) begin
      errors++; $display("FAIL wrap_ret got v=%b p=%0d h=%0d exp 1111 14 2", commitVld_o, commitPtr_o, head_o); end
  endtask

  task automatic test_partial();
    clr_ram();
    ram[2] = 8'h01; ram[3] = 8'h00; ram[4] = 8'h01; ram[5] = 8'h01;
    dispatchCnt_i = 3'd4;
    step();
    dispatchCnt_i = 3'd0;
    step();
    checks++; if (commitVld_o !== 4'b0001 || head_o !== 4'd3 || alCount_o !== 5'd3) begin
      errors++; $display("FAIL partial got v=%b h=%0d c=%0d exp 0001 3 3", commitVld_o, head_o, alCount_o); end
    step();
    checks++; if (commitVld_o !== 4'b0000 || head_o !== 4'd3) begin
      errors++; $display("FAIL not_done got v=%b h=%0d exp 0000 3", commitVld_o, head_o); end
    ram[3] = 8'hF1;
    step();
    checks++; if (commitVld_o !== 4'b0111 || commitCnt_o !== 3'd3 || head_o !== 4'd6) begin
      errors++; $display("FAIL three got v=%b n=%0d h=%0d exp 0111 3 6", commitVld_o, commitCnt_o, head_o); end
  endtask

  task automatic test_mispredict_flush();
    clr_ram();
    ram[6] = 8'h01; ram[7] = 8'h05; ram[8] = 8'h01; ram[9] = 8'h01;
    dispatchCnt_i = 3'd4;
    step();
    dispatchCnt_i = 3'd0;
    step();
    checks++; if (commitVld_o !== 4'b0011 || head_o !== 4'd8 || alCount_o !== 5'd2) begin
      errors++; $display("FAIL mispred got v=%b h=%0d c=%0d exp 0011 8 2", commitVld_o, head_o, alCount_o); end
    ram[8] = 8'h03;
    step();
    checks++; if (recoverFlag_o !== 1'b1 || commitVld_o !== 4'b0 || head_o !== 4'd8) begin
      errors++; $display("FAIL excpt got rec=%b v=%b h=%0d exp 1 0000 8", recoverFlag_o, commitVld_o, head_o); end
    dispatchCnt_i = 3'd3;
    step();
    step();
    checks++; if (recoverFlag_o !== 1'b1 || tail_o !== 4'd10 || alCount_o !== 5'd2) begin
      errors++; $display("FAIL flush_hold got rec=%b t=%0d c=%0d exp 1 10 2", recoverFlag_o, tail_o, alCount_o); end
    dispatchCnt_i = 3'd0;
    flushAck_i = 1'b1;
    step();
    flushAck_i = 1'b0;
    checks++; if (recoverFlag_o !== 1'b0 || head_o !== 4'd0 || tail_o !== 4'd0 || alCount_o !== 5'd0) begin
      errors++; $display("FAIL flush_ack got rec=%b h=%0d t=%0d c=%0d exp 0 0 0 0", recoverFlag_o, head_o, tail_o, alCount_o); end
  endtask

  task automatic test_lanes_stall();
    clr_ram();
    for (int i = 0; i < 4; i++) ram[i] = 8'h01;
    flushAck_i = 1'b1;
    commitLaneActive_i = 4'b0011;
    dispatchCnt_i = 3'd4;
    step();
    flushAck_i = 1'b0;
    dispatchCnt_i = 3'd0;
    step();
    checks++; if (commitVld_o !== 4'b0011 || head_o !== 4'd2 || alCount_o !== 5'd2) begin
      errors++; $display("FAIL lanes got v=%b h=%0d c=%0d exp 0011 2 2", commitVld_o, head_o, alCount_o); end
    commitLaneActive_i = 4'b1111;
    stallCommit_i = 1'b1;
    step();
    checks++; if (commitVld_o !== 4'b0 || head_o !== 4'd2) begin
      errors++; $display("FAIL stall got v=%b h=%0d exp 0000 2", commitVld_o, head_o); end
    stallCommit_i = 1'b0;
    commitLaneActive_i = 4'b0000;
    step();
    checks++; if (commitVld_o !== 4'b0 || head_o !== 4'd2) begin
      errors++; $display("FAIL lane0_off got v=%b h=%0d exp 0000 2", commitVld_o, head_o); end
    commitLaneActive_i = 4'b1111;
    step();
    checks++; if (commitVld_o !== 4'b0011 || head_o !== 4'd4 || alCount_o !== 5'd0) begin
      errors++; $display("FAIL resume got v=%b h=%0d c=%0d exp 0011 4 0", commitVld_o, head_o, alCount_o); end
  endtask

  task automatic test_full_reset();
    clr_ram();
    dispatchCnt_i = 3'd4;
    step();
    step();
    step();
    checks++; if (alCount_o !== 5'd12 || alFull_o !== 1'b0) begin
      errors++; $display("FAIL cnt12 got c=%0d f=%b exp 12 0", alCount_o, alFull_o); end
    dispatchCnt_i = 3'd1;
    step();
    checks++; if (alCount_o !== 5'd13 || alFull_o !== 1'b1) begin
      errors++; $display("FAIL cnt13 got c=%0d f=%b exp 13 1", alCount_o, alFull_o); end
    ram[4] = 8'h01; ram[5] = 8'h01; ram[6] = 8'h01;
    dispatchCnt_i = 3'd2;
    step();
    checks++; if (alCount_o !== 5'd12 || alFull_o !== 1'b0 || commitCnt_o !== 3'd3) begin
      errors++; $display("FAIL disp_ret got c=%0d f=%b n=%0d exp 12 0 3", alCount_o, alFull_o, commitCnt_o); end
    checks++; if (head_o !== 4'd7 || tail_o !== 4'd3) begin
      errors++; $display("FAIL disp_ret_ptr got h=%0d t=%0d exp 7 3", head_o, tail_o); end
    dispatchCnt_i = 3'd0;
    ram[7] = 8'h03;
    step();
    checks++; if (recoverFlag_o !== 1'b1) begin
      errors++; $display("FAIL flush2 got rec=%b exp 1", recoverFlag_o); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++; if (recoverFlag_o !== 1'b0 || head_o !== 4'd0 || tail_o !== 4'd0 || alCount_o !== 5'd0) begin
      errors++; $display("FAIL mid_rst got rec=%b h=%0d t=%0d c=%0d exp 0 0 0 0", recoverFlag_o, head_o, tail_o, alCount_o); end
    checks++; if (commitPtr_o !== 4'd0 || commitCnt_o !== 3'd0 || alFull_o !== 1'b0) begin
      errors++; $display("FAIL mid_rst_out got p=%0d n=%0d f=%b exp 0 0 0", commitPtr_o, commitCnt_o, alFull_o); end
    step();
    checks++; if (recoverFlag_o !== 1'b0) begin
      errors++; $display("FAIL post_rst got rec=%b exp 0", recoverFlag_o); end
  endtask

  initial begin
    reset = 1'b1;
    dispatchCnt_i = 3'd0;
    commitLaneActive_i = 4'b1111;
    stallCommit_i = 1'b0;
    flushAck_i = 1'b0;
    clr_ram();
    test_reset();
    test_full_group();
    test_wrap();
    test_partial();
    test_mispredict_flush();
    test_lanes_stall();
    test_full_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
